vector_load_store_burst: RTL and testbench

//  Parametrised vector load/store unit: moves 1..VLEN fixed-point elements between the vector

---
 rtl/config_pkg.sv | 31 +++
 rtl/vls_beat_buffer.sv | 42 ++++
 rtl/vector_load_store_burst.sv | 198 +++++++++++++++++++
 tb/tb_vector_load_store_burst.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared widths, operation codes and FSM states for the vector load/store burst unit.
package config_pkg;

   localparam int CFG_DATA_W     = 16;
   localparam int CFG_LANES      = 4;
   localparam int CFG_VLEN       = 64;
   localparam int CFG_DI_W       = 6;
   localparam int CFG_DDR_ADDR_W = 32;
   localparam int CFG_STRIDE_W   = 16;

   typedef enum logic [1:0] {
      LS_NOP   = 2'd0,
      LS_LOAD  = 2'd1,
      LS_STORE = 2'd2
   } load_store_op_e;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LD_REQ    = 3'd1,
      LD_WAIT   = 3'd2,
      LD_UNPACK = 3'd3,
      ST_GATHER = 3'd4,
      ST_WRITE  = 3'd5,
      DONE      = 3'd6
   } vls_state_e;

   typedef logic [CFG_DATA_W-1:0]           fixed_point_t;
   typedef logic [CFG_DDR_ADDR_W-1:0]       ddr_address_t;
   typedef logic [CFG_LANES*CFG_DATA_W-1:0] ddr_data_t;

endpackage

// File: rtl/vls_beat_buffer.sv
// One DDR word of lanes: loaded whole and read lane-by-lane for loads,
// cleared then filled lane-by-lane for stores.
module vls_beat_buffer #(
   parameter int DATA_W = 16,
   parameter int LANES  = 4,
   parameter int LANE_W = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    load_i,
   input  logic [LANES*DATA_W-1:0] load_data_i,
   input  logic                    clr_i,
   input  logic                    wr_i,
   input  logic [LANE_W-1:0]       wr_lane_i,
   input  logic [DATA_W-1:0]       wr_data_i,
   input  logic [LANE_W-1:0]       rd_lane_i,
   output logic [DATA_W-1:0]       rd_data_o,
   output logic [LANES*DATA_W-1:0] word_o
);

   logic [LANES-1:0][DATA_W-1:0] buf_q, buf_d;

   always_comb begin
      buf_d = buf_q;
      if (clr_i) begin
         buf_d = '0;
      end else if (load_i) begin
         buf_d = load_data_i;
      end else if (wr_i) begin
         buf_d[wr_lane_i] = wr_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) buf_q <= '0;
      else         buf_q <= buf_d;
   end

   assign rd_data_o = buf_q[rd_lane_i];
   assign word_o    = buf_q;

endmodule

// File: rtl/vector_load_store_burst.sv
// Vector load/store unit: moves up to VLEN elements between the vector memory and DDR,
// LANES elements per strided DDR beat, with a partial final beat.
module vector_load_store_burst
   import config_pkg::*;
#(
   parameter int DATA_W     = CFG_DATA_W,
   parameter int LANES      = CFG_LANES,
   parameter int VLEN       = CFG_VLEN,
   parameter int DI_W       = CFG_DI_W,
   parameter int DDR_ADDR_W = CFG_DDR_ADDR_W,
   parameter int STRIDE_W   = CFG_STRIDE_W
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [1:0]              op_i,
   input  logic [DDR_ADDR_W-1:0]   base_addr_i,
   input  logic [STRIDE_W-1:0]     stride_i,
   input  logic [DI_W:0]           len_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   output logic                    done_o,
   output logic [DI_W-1:0]         vec_addr_o,
   input  logic [DATA_W-1:0]       vec_r_data_i,
   output logic [DATA_W-1:0]       vec_w_data_o,
   output logic                    vec_w_en_o,
   output logic [DDR_ADDR_W-1:0]   ddr_address_o,
   output logic                    ddr_r_en_o,
   input  logic [LANES*DATA_W-1:0] ddr_r_data_i,
   input  logic                    ddr_r_valid_i,
   output logic                    ddr_w_en_o,
   output logic [LANES*DATA_W-1:0] ddr_w_data_o,
   input  logic                    ddr_w_done_i,
   output vls_state_e              state_o
);

   // Issue handshake: a request is taken on in_valid_i && in_ready_o; in_ready_o is
   // high only in IDLE, so at most one operation is in flight.
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int LCNT_W = LANE_W + 1;
   localparam int LEN_W  = DI_W + 1;
   localparam logic [LCNT_W-1:0] LANES_C = LCNT_W'(LANES);
   localparam logic [LEN_W-1:0]  VLEN_C  = LEN_W'(VLEN);

   vls_state_e              state_q, state_d;
   logic [DDR_ADDR_W-1:0]   addr_q, addr_d, addr_step;
   logic [STRIDE_W-1:0]     stride_q, stride_d;
   logic [LEN_W-1:0]        len_q, len_d, len_clamped;
   logic [LEN_W-1:0]        elem_q, elem_d, elem_nxt;
   logic [LCNT_W-1:0]       lane_q, lane_d, lane_nxt;
   logic                    pend_q, pend_d;
   logic [LANE_W-1:0]       pend_lane_q, pend_lane_d;
   logic                    buf_load, buf_clr, buf_wr;
   logic [DATA_W-1:0]       buf_rd_data;
   logic [LANES*DATA_W-1:0] buf_word;
   logic [DI_W-1:0]         vec_addr;
   logic                    vec_w_en;

   assign len_clamped = (len_i > VLEN_C) ? VLEN_C : len_i;
   assign elem_nxt    = elem_q + LEN_W'(1);
   assign lane_nxt    = lane_q + LCNT_W'(1);
   assign addr_step   = addr_q + DDR_ADDR_W'(stride_q);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      stride_d    = stride_q;
      len_d       = len_q;
      elem_d      = elem_q;
      lane_d      = lane_q;
      pend_d      = pend_q;
      pend_lane_d = pend_lane_q;
      buf_load    = 1'b0;
      buf_clr     = 1'b0;
      buf_wr      = 1'b0;
      vec_addr    = '0;
      vec_w_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               addr_d   = base_addr_i;
               stride_d = stride_i;
               len_d    = len_clamped;
               elem_d   = '0;
               lane_d   = '0;
               pend_d   = 1'b0;
               if (len_clamped != '0 && op_i == LS_LOAD) begin
                  state_d = LD_REQ;
               end else if (len_clamped != '0 && op_i == LS_STORE) begin
                  buf_clr = 1'b1;
                  state_d = ST_GATHER;
               end else begin
                  state_d = DONE;
               end
            end
         end
         LD_REQ: state_d = LD_WAIT;
         LD_WAIT: begin
            if (ddr_r_valid_i) begin
               buf_load = 1'b1;
               state_d  = LD_UNPACK;
            end
         end
         LD_UNPACK: begin
            vec_w_en = 1'b1;
            vec_addr = elem_q[DI_W-1:0];
            elem_d   = elem_nxt;
            lane_d   = lane_nxt;
            if (elem_nxt == len_q) begin
               state_d = DONE;
            end else if (lane_nxt == LANES_C) begin
               lane_d  = '0;
               addr_d  = addr_step;
               state_d = LD_REQ;
            end
         end
         ST_GATHER: begin
            // Read data for the index issued last cycle lands in its lane this cycle.
            buf_wr = pend_q;
            pend_d = 1'b0;
            if (lane_q != LANES_C && elem_q != len_q) begin
               vec_addr    = elem_q[DI_W-1:0];
               elem_d      = elem_nxt;
               lane_d      = lane_nxt;
               pend_d      = 1'b1;
               pend_lane_d = lane_q[LANE_W-1:0];
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (ddr_w_done_i) begin
               if (elem_q == len_q) begin
                  state_d = DONE;
               end else begin
                  addr_d  = addr_step;
                  lane_d  = '0;
                  buf_clr = 1'b1;
                  state_d = ST_GATHER;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         stride_q    <= '0;
         len_q       <= '0;
         elem_q      <= '0;
         lane_q      <= '0;
         pend_q      <= 1'b0;
         pend_lane_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         stride_q    <= stride_d;
         len_q       <= len_d;
         elem_q      <= elem_d;
         lane_q      <= lane_d;
         pend_q      <= pend_d;
         pend_lane_q <= pend_lane_d;
      end
   end

   vls_beat_buffer #(
      .DATA_W (DATA_W),
      .LANES  (LANES),
      .LANE_W (LANE_W)
   ) u_beat_buffer (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .load_i      (buf_load),
      .load_data_i (ddr_r_data_i),
      .clr_i       (buf_clr),
      .wr_i        (buf_wr),
      .wr_lane_i   (pend_lane_q),
      .wr_data_i   (vec_r_data_i),
      .rd_lane_i   (lane_q[LANE_W-1:0]),
      .rd_data_o   (buf_rd_data),
      .word_o      (buf_word)
   );

   assign in_ready_o    = (state_q == IDLE);
   assign done_o        = (state_q == DONE);
   assign ddr_r_en_o    = (state_q == LD_REQ);
   assign ddr_w_en_o    = (state_q == ST_WRITE);
   assign ddr_address_o = (ddr_r_en_o || ddr_w_en_o) ? addr_q : '0;
   assign ddr_w_data_o  = ddr_w_en_o ? buf_word : '0;
   assign vec_addr_o    = vec_addr;
   assign vec_w_en_o    = vec_w_en;
   assign vec_w_data_o  = vec_w_en ? buf_rd_data : '0;
   assign state_o       = state_q;

endmodule

// File: tb/tb_vector_load_store_burst.sv
// Randomised bench for vector_load_store_burst: DDR and vector-memory responders plus a
// queue-based reference of every DDR access and vector write an operation must produce.
module tb_vector_load_store_burst;
   import config_pkg::*;

   localparam int DATA_W = 16;
   localparam int LANES  = 4;
   localparam int VLEN   = 64;
   localparam int DI_W   = 6;
   localparam int AW     = 32;
   localparam int SW     = 16;
   localparam int DW     = LANES * DATA_W;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic [1:0]        op_i = '0;
   logic [AW-1:0]     base_addr_i = '0;
   logic [SW-1:0]     stride_i = '0;
   logic [DI_W:0]     len_i = '0;
   logic              in_valid_i = 1'b0;
   logic              in_ready_o, done_o, vec_w_en_o, ddr_r_en_o, ddr_w_en_o;
   logic [DI_W-1:0]   vec_addr_o;
   logic [DATA_W-1:0] vec_r_data_i = '0;
   logic [DATA_W-1:0] vec_w_data_o;
   logic [AW-1:0]     ddr_address_o;
   logic [DW-1:0]     ddr_r_data_i = '0;
   logic              ddr_r_valid_i = 1'b0;
   logic [DW-1:0]     ddr_w_data_o;
   logic              ddr_w_done_i = 1'b0;
   vls_state_e        state_o;

   vector_load_store_burst dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .op_i          (op_i),
      .base_addr_i   (base_addr_i),
      .stride_i      (stride_i),
      .len_i         (len_i),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .done_o        (done_o),
      .vec_addr_o    (vec_addr_o),
      .vec_r_data_i  (vec_r_data_i),
      .vec_w_data_o  (vec_w_data_o),
      .vec_w_en_o    (vec_w_en_o),
      .ddr_address_o (ddr_address_o),
      .ddr_r_en_o    (ddr_r_en_o),
      .ddr_r_data_i  (ddr_r_data_i),
      .ddr_r_valid_i (ddr_r_valid_i),
      .ddr_w_en_o    (ddr_w_en_o),
      .ddr_w_data_o  (ddr_w_data_o),
      .ddr_w_done_i  (ddr_w_done_i),
      .state_o       (state_o)
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- scoreboard state ----------------
   int n_vec = 0;
   int n_err = 0;

   logic [DATA_W-1:0]      vmem [VLEN];
   logic [DI_W+DATA_W-1:0] exp_vw_q [$];
   logic [AW-1:0]          exp_ra_q [$];
   logic [AW-1:0]          exp_wa_q [$];
   logic [DW-1:0]          exp_wd_q [$];

   bit            rd_mute = 1'b0;
   bit            rd_busy = 1'b0;
   int            rd_cnt = 0;
   int            lat_min = 1;
   int            lat_max = 4;
   logic [AW-1:0] rd_addr = '0;
   bit            w_act = 1'b0;
   int            w_hold = 0;
   int            w_cycles = 0;
   int            w_exp_cycles = 0;
   int            hold_fix = 0;
   logic [AW-1:0] w_addr = '0;
   logic [DW-1:0] w_data = '0;
   logic [DI_W-1:0] vprev = '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // DDR memory contents: a fixed scramble of the word address.
   function automatic logic [DW-1:0] ddr_word(input logic [AW-1:0] a);
      logic [DW-1:0] w;
      for (int l = 0; l < LANES; l++)
         w[l*DATA_W +: DATA_W] = (a[15:0] * 16'd37 + 16'(l) * 16'h1111) ^ a[31:16];
      return w;
   endfunction

   // ---------------- responders and monitor (sample/drive on negedge) ----------------
   initial forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
         rd_busy = 1'b0;
         w_act = 1'b0;
         ddr_r_valid_i = 1'b0;
         ddr_w_done_i = 1'b0;
         continue;
      end
      vec_r_data_i = vmem[vprev];
      vprev = vec_addr_o;
      if (vec_w_en_o) begin
         if (exp_vw_q.size() == 0) check("vec_wr_extra", 128'(1), 128'(0));
         else check("vec_wr", 128'({vec_addr_o, vec_w_data_o}), 128'(exp_vw_q.pop_front()));
      end
      ddr_r_valid_i = 1'b0;
      ddr_r_data_i = {$urandom, $urandom};
      if (rd_busy) begin
         rd_cnt--;
         if (rd_cnt == 0) begin
            ddr_r_valid_i = 1'b1;
            ddr_r_data_i = ddr_word(rd_addr);
            rd_busy = 1'b0;
         end
      end
      if (ddr_r_en_o) begin
         if (exp_ra_q.size() == 0) check("ddr_rd_extra", 128'(1), 128'(0));
         else check("ddr_rd_addr", 128'(ddr_address_o), 128'(exp_ra_q.pop_front()));
         rd_addr = ddr_address_o;
         if (!rd_mute) begin
            rd_busy = 1'b1;
            rd_cnt = $urandom_range(lat_min, lat_max);
         end
      end
      ddr_w_done_i = 1'b0;
      if (ddr_w_en_o) begin
         if (!w_act) begin
            w_act = 1'b1;
            w_cycles = 0;
            w_addr = ddr_address_o;
            w_data = ddr_w_data_o;
            w_hold = (hold_fix > 0) ? hold_fix : $urandom_range(1, 3);
            w_exp_cycles = w_hold + 1;
            if (exp_wa_q.size() == 0) begin
               check("ddr_wr_extra", 128'(1), 128'(0));
            end else begin
               check("ddr_wr_addr", 128'(ddr_address_o), 128'(exp_wa_q.pop_front()));
               check("ddr_wr_data", 128'(ddr_w_data_o), 128'(exp_wd_q.pop_front()));
            end
         end else begin
            check("ddr_wr_stable", 128'({ddr_address_o, ddr_w_data_o}), 128'({w_addr, w_data}));
         end
         w_cycles++;
         if (w_hold == 0) ddr_w_done_i = 1'b1;
         else w_hold--;
      end else if (w_act) begin
         w_act = 1'b0;
         check("ddr_wr_cycles", 128'(w_cycles), 128'(w_exp_cycles));
      end
   end

   // ---------------- driver: one operation, reference built up front ----------------
   task automatic run_op(input logic [1:0] op, input logic [AW-1:0] base, input logic [SW-1:0] stride,
                         input logic [DI_W:0] len, input int hold, input int exp_cyc);
      int l, beats, cycles, dones;
      bit rdy_bad;
      logic [AW-1:0] a;
      logic [DW-1:0] w;
      hold_fix = hold;
      for (int i = 0; i < VLEN; i++) vmem[i] = DATA_W'($urandom);
      l = (int'(len) > VLEN) ? VLEN : int'(len);
      beats = (op == LS_LOAD || op == LS_STORE) ? (l + LANES - 1) / LANES : 0;
      for (int b = 0; b < beats; b++) begin
         a = base + AW'(b) * AW'(stride);
         if (op == LS_LOAD) begin
            exp_ra_q.push_back(a);
            w = ddr_word(a);
            for (int e = b * LANES; e < l && e < (b + 1) * LANES; e++)
               exp_vw_q.push_back({DI_W'(e), w[(e % LANES)*DATA_W +: DATA_W]});
         end else begin
            w = '0;
            for (int e = b * LANES; e < l && e < (b + 1) * LANES; e++)
               w[(e % LANES)*DATA_W +: DATA_W] = vmem[e];
            exp_wa_q.push_back(a);
            exp_wd_q.push_back(w);
         end
      end
      @(negedge clk_i);
      op_i = op;
      base_addr_i = base;
      stride_i = stride;
      len_i = len;
      in_valid_i = 1'b1;
      check("ready_idle", 128'(in_ready_o), 128'(1));
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      op_i = 2'($urandom);
      base_addr_i = $urandom;
      len_i = 7'($urandom);
      cycles = 0;
      dones = 0;
      rdy_bad = 1'b0;
      while (dones == 0 && cycles < 3000) begin
         @(negedge clk_i);
         cycles++;
         if (done_o) dones++;
         else if (in_ready_o) rdy_bad = 1'b1;
      end
      check("done_seen", 128'(dones), 128'(1));
      if (beats == 0) check("nop_latency", 128'(cycles), 128'(1));
      if (exp_cyc > 0) check("op_latency", 128'(cycles), 128'(exp_cyc));
      check("ready_low_busy", 128'(rdy_bad), 128'(0));
      repeat (3) begin
         @(negedge clk_i);
         if (done_o) dones++;
      end
      check("done_once", 128'(dones), 128'(1));
      check("ready_after", 128'(in_ready_o), 128'(1));
      check("left_vec_wr", 128'(exp_vw_q.size()), 128'(0));
      check("left_ddr_rd", 128'(exp_ra_q.size()), 128'(0));
      check("left_ddr_wr", 128'(exp_wa_q.size()), 128'(0));
      exp_vw_q.delete();
      exp_ra_q.delete();
      exp_wa_q.delete();
      exp_wd_q.delete();
      hold_fix = 0;
   endtask

   // Abort a load in LD_WAIT with reset, then feed stray DDR responses while idle.
   task automatic reset_mid_load();
      int n, bad_w, bad_d, bad_r;
      rd_mute = 1'b1;
      exp_ra_q.push_back(32'h0000_0700);
      @(negedge clk_i);
      op_i = LS_LOAD;
      base_addr_i = 32'h0000_0700;
      stride_i = 16'd1;
      len_i = 7'd8;
      in_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      n = 0;
      while (!ddr_r_en_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      check("rst_req_seen", 128'(ddr_r_en_o), 128'(1));
      repeat (2) @(negedge clk_i);
      check("rst_in_ld_wait", 128'(state_o), 128'(LD_WAIT));
      #2 rst_ni = 1'b0;
      #1;
      check("rst_abort_outs", 128'({in_ready_o, done_o, ddr_r_en_o, vec_w_en_o}), 128'(4'b1000));
      exp_ra_q.delete();
      exp_vw_q.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
      rd_mute = 1'b0;
      @(negedge clk_i);
      #1;
      ddr_r_valid_i = 1'b1;
      ddr_w_done_i = 1'b1;
      ddr_r_data_i = {$urandom, $urandom};
      bad_w = 0;
      bad_d = 0;
      bad_r = 0;
      repeat (5) begin
         @(negedge clk_i);
         if (vec_w_en_o) bad_w++;
         if (done_o) bad_d++;
         if (!in_ready_o) bad_r++;
      end
      check("stray_no_vec_wr", 128'(bad_w), 128'(0));
      check("stray_no_done", 128'(bad_d), 128'(0));
      check("stray_ready", 128'(bad_r), 128'(0));
   endtask

   // ---------------- main sequence and report ----------------
   initial begin
      int r;
      logic [1:0] op;
      logic [SW-1:0] stride;
      for (int i = 0; i < VLEN; i++) vmem[i] = '0;
      repeat (3) @(negedge clk_i);
      check("rst_outputs",
            128'({in_ready_o, done_o, ddr_r_en_o, ddr_w_en_o, vec_w_en_o, vec_addr_o,
                  ddr_address_o, ddr_w_data_o, vec_w_data_o}),
            128'({1'b1, 122'd0}));
      rst_ni = 1'b1;

      lat_min = 1;
      lat_max = 1;
      run_op(LS_LOAD, 32'h0000_0100, 16'd1, 7'd8, 0, 13);
      lat_max = 4;
      run_op(LS_STORE, 32'h0000_0200, 16'd4, 7'd6, 5, 0);
      run_op(LS_LOAD, 32'h0000_0300, 16'd2, 7'd0, 0, 0);
      run_op(LS_STORE, 32'h0000_0300, 16'd2, 7'd0, 0, 0);
      run_op(LS_NOP, 32'h0000_0400, 16'd1, 7'd8, 0, 0);
      run_op(LS_LOAD, 32'hFFFF_FFFF, 16'd1, 7'd8, 0, 0);
      reset_mid_load();
      run_op(LS_STORE, 32'h0000_0500, 16'd0, 7'(VLEN + 5), 0, 0);
      run_op(LS_LOAD, 32'h0000_0600, 16'd3, 7'd5, 0, 0);

      repeat (24) begin
         r = $urandom_range(0, 9);
         op = (r == 0) ? LS_NOP : (r < 5) ? LS_LOAD : LS_STORE;
         stride = ($urandom_range(0, 1) == 1) ? SW'($urandom) : SW'($urandom_range(0, 3));
         run_op(op, $urandom, stride, 7'($urandom_range(0, 127)), 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
